// File: rtl/mat_mul_seq.sv
// Sequential matrix multiply controller: one external dot unit computes the I*K outputs one pair per cycle.
// Optional performance counters are enabled by defining MAT_MUL_SEQ_PERF_CNT_EN.
module mat_mul_seq #(
  parameter int EXP_WIDTH   = 8,
  parameter int FRAC_WIDTH  = 23,
  parameter int I           = 4,
  parameter int J           = 4,
  parameter int K           = 4,
  parameter int DOT_LATENCY = 2,
  localparam int FW         = 1 + EXP_WIDTH + FRAC_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [I*J*FW-1:0] lhs,
  input  logic [J*K*FW-1:0] rhs,
  output logic [J*FW-1:0]   dot_lhs,
  output logic [J*FW-1:0]   dot_rhs,
  input  logic [FW-1:0]     dot_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [I*K*FW-1:0] out,
  output logic              busy
`ifdef MAT_MUL_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]       job_count,
  output logic [31:0]       stall_count
`endif
);

  localparam int NIDX = I * K;
  localparam int NW   = (NIDX > 1) ? $clog2(NIDX) : 1;
  localparam logic [NW-1:0] LAST_N = NW'(NIDX - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and out holds steady while out_valid waits for out_ready.
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state;
  state_t            state_d;
  logic [NW-1:0]     n;
  logic [NW-1:0]     last_n;
  logic [NW-1:0]     sel_n;
  int                sel_row;
  int                sel_col;
  logic [I*J*FW-1:0] lhs_q;
  logic [J*K*FW-1:0] rhs_q;
  logic [DOT_LATENCY-1:0] pipe_v;
  logic [NW-1:0]     pipe_n [DOT_LATENCY];
  logic [FW-1:0]     out_mem [NIDX];
  logic              wr_en;
  logic [NW-1:0]     wr_n;
  logic              accept;

  assign accept = in_valid && in_ready;
  assign wr_en  = pipe_v[DOT_LATENCY-1];
  assign wr_n   = pipe_n[DOT_LATENCY-1];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ISSUE;
      end
      ISSUE: begin
        busy = 1'b1;
        if (n == LAST_N) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (wr_en && (wr_n == LAST_N)) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n      <= '0;
      last_n <= '0;
      lhs_q  <= '0;
      rhs_q  <= '0;
      pipe_v <= '0;
      for (int s = 0; s < DOT_LATENCY; s++) pipe_n[s] <= '0;
      for (int e = 0; e < NIDX; e++) out_mem[e] <= '0;
    end else begin
      if (accept) begin
        lhs_q <= lhs;
        rhs_q <= rhs;
        n     <= '0;
      end else if (state == ISSUE) begin
        last_n <= n;
        if (n != LAST_N) n <= n + 1'b1;
      end
      // Fixed-latency tag pipe mirrors the dot unit so each result lands in its own slot.
      pipe_v[0] <= (state == ISSUE);
      pipe_n[0] <= n;
      for (int s = 1; s < DOT_LATENCY; s++) begin
        pipe_v[s] <= pipe_v[s-1];
        pipe_n[s] <= pipe_n[s-1];
      end
      for (int e = 0; e < NIDX; e++) begin
        if (wr_en && (wr_n == NW'(e))) out_mem[e] <= dot_result;
      end
    end
  end

  // Outside ISSUE the operand ports keep showing the last pair that was issued.
  always_comb begin
    sel_n   = (state == ISSUE) ? n : last_n;
    sel_row = int'(sel_n) / K;
    sel_col = int'(sel_n) % K;
    dot_lhs = '0;
    dot_rhs = '0;
    for (int r = 0; r < I; r++) begin
      if (sel_row == r) dot_lhs = lhs_q[r*J*FW +: J*FW];
    end
    for (int j = 0; j < J; j++) begin
      for (int c = 0; c < K; c++) begin
        if (sel_col == c) dot_rhs[j*FW +: FW] = rhs_q[(j*K+c)*FW +: FW];
      end
    end
  end

  for (genvar e = 0; e < NIDX; e++) begin : g_out
    assign out[e*FW +: FW] = out_mem[e];
  end

`ifdef MAT_MUL_SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      job_count   <= '0;
      stall_count <= '0;
    end else begin
      if (accept && (job_count != '1)) job_count <= job_count + 32'd1;
      if ((state == DONE) && !out_ready && (stall_count != '1))
        stall_count <= stall_count + 32'd1;
    end
  end
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mat_mul_seq.sv
// Directed bench for mat_mul_seq (I=2, J=2, K=3, FP32, DOT_LATENCY=2) with a behavioural dot unit.
// Define MAT_MUL_SEQ_PERF_CNT_EN to also exercise the performance counters.
module tb_mat_mul_seq;
  localparam int I = 2;
  localparam int J = 2;
  localparam int K = 3;
  localparam int L = 2;
  localparam int FW = 32;
  localparam int LAT = I * K + L + 1;
  localparam int PERIOD = I * K + L + 2;

  localparam logic [I*J*FW-1:0] ID_M  = {32'h3F800000, 32'h0, 32'h0, 32'h3F800000};
  localparam logic [I*J*FW-1:0] TWO_M = {32'h40000000, 32'h0, 32'h0, 32'h40000000};
  localparam logic [I*J*FW-1:0] A_M   = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
  localparam logic [J*K*FW-1:0] B_M   = {32'h40C00000, 32'h40A00000, 32'h40800000,
                                         32'h40400000, 32'h40000000, 32'h3F800000};
  localparam logic [J*K*FW-1:0] R_M   = {32'h40E00000, 32'h40C00000, 32'h40A00000,
                                         32'h40800000, 32'h40400000, 32'h40000000};
  localparam logic [I*K*FW-1:0] P_AB  = {32'h42040000, 32'h41D00000, 32'h41980000,
                                         32'h41700000, 32'h41400000, 32'h41100000};
  localparam logic [I*K*FW-1:0] P_2B  = {32'h41400000, 32'h41200000, 32'h41000000,
                                         32'h40C00000, 32'h40800000, 32'h40000000};

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [I*J*FW-1:0] lhs;
  logic [J*K*FW-1:0] rhs;
  logic [J*FW-1:0]   dot_lhs;
  logic [J*FW-1:0]   dot_rhs;
  logic [FW-1:0]     dot_result;
  logic              out_valid;
  logic              out_ready;
  logic [I*K*FW-1:0] out;
  logic              busy;
`ifdef MAT_MUL_SEQ_PERF_CNT_EN
  logic [31:0]       job_count;
  logic [31:0]       stall_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int dot_mode = 0;
  logic [I*K*FW-1:0] exp_q[$];
  logic [FW-1:0] mpipe [L];

  mat_mul_seq #(
    .EXP_WIDTH(8), .FRAC_WIDTH(23), .I(I), .J(J), .K(K), .DOT_LATENCY(L)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .lhs(lhs), .rhs(rhs), .dot_lhs(dot_lhs), .dot_rhs(dot_rhs),
    .dot_result(dot_result), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .busy(busy)
`ifdef MAT_MUL_SEQ_PERF_CNT_EN
    , .job_count(job_count), .stall_count(stall_count)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- dot unit model ----------------
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  function automatic logic [31:0] model_dot(input logic [J*FW-1:0] a, input logic [J*FW-1:0] b,
                                            input int mode);
    real s;
    if (mode == 1) return {16'hC000, a[7:0], b[7:0]};
    s = 0.0;
    for (int j = 0; j < J; j++) s = s + f2r(a[j*FW +: FW]) * f2r(b[j*FW +: FW]);
    return r2f(s);
  endfunction

  always @(posedge clk) begin
    mpipe[0] <= model_dot(dot_lhs, dot_rhs, dot_mode);
    for (int s = 1; s < L; s++) mpipe[s] <= mpipe[s-1];
  end
  assign dot_result = mpipe[L-1];

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle into ISSUE (cycle 1 relative to the accept edge).
  task automatic accept_job(input logic [I*J*FW-1:0] l, input logic [J*K*FW-1:0] r);
    lhs = l;
    rhs = r;
    in_valid = 1'b1;
    for (int t = 0; t < 50 && !in_ready; t++) step();
    if (!in_ready) begin
      n_checks++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit rdy_low);
    cyc = 1;
    rdy_low = 1'b1;
    while (!out_valid && cyc < 60) begin
      if (in_ready) rdy_low = 1'b0;
      step();
      cyc++;
    end
    if (in_ready) rdy_low = 1'b0;
    if (!out_valid) begin
      n_checks++;
      $display("FAIL done_timeout: out_valid=%0b required 1", out_valid);
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; lhs = '0; rhs = '0;
    step(); step();
    rst = 1'b0;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %0b need 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %0b need 0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b need 0", busy); else n_pass++;
    n_checks++; if (out !== '0) $display("FAIL rst_out: got %h need 0", out); else n_pass++;
    n_checks++; if (dot_lhs !== '0) $display("FAIL rst_dot_lhs: got %h need 0", dot_lhs); else n_pass++;
    n_checks++; if (dot_rhs !== '0) $display("FAIL rst_dot_rhs: got %h need 0", dot_rhs); else n_pass++;
  endtask

  task automatic test_single();
    int cyc;
    bit rdy_low;
    accept_job(ID_M, R_M);
    n_checks++; if (busy !== 1'b1) $display("FAIL single_busy: got %0b need 1", busy); else n_pass++;
    wait_done(cyc, rdy_low);
    n_checks++; if (cyc != LAT) $display("FAIL single_latency: got %0d need %0d", cyc, LAT); else n_pass++;
    n_checks++; if (!rdy_low) $display("FAIL single_in_ready_low: got 0 need 1"); else n_pass++;
    n_checks++; if (out !== R_M) $display("FAIL single_out: got %h need %h", out, R_M); else n_pass++;
    handshake();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL single_out_valid_after: got %0b need 0", out_valid); else n_pass++;
    n_checks++; if (out !== R_M) $display("FAIL single_out_retained: got %h need %h", out, R_M); else n_pass++;
  endtask

  task automatic test_ordering();
    logic [J*K*FW-1:0] tr;
    logic [I*J*FW-1:0] tl;
    logic [I*K*FW-1:0] expo;
    logic [FW-1:0] el;
    logic [J*FW-1:0] exl;
    logic [J*FW-1:0] exr;
    int cyc;
    bit rdy_low;
    dot_mode = 1;
    for (int r = 0; r < I; r++)
      for (int j = 0; j < J; j++) tl[(r*J+j)*FW +: FW] = 32'hA0000000 + 32'(r);
    for (int j = 0; j < J; j++)
      for (int c = 0; c < K; c++) tr[(j*K+c)*FW +: FW] = 32'hB0000000 + 32'(c);
    for (int n = 0; n < I*K; n++) expo[n*FW +: FW] = {16'hC000, 8'(n / K), 8'(n % K)};
    accept_job(tl, tr);
    for (int n = 0; n < I*K; n++) begin
      el = 32'hA0000000 + 32'(n / K); exl = {el, el};
      el = 32'hB0000000 + 32'(n % K); exr = {el, el};
      n_checks++; if (dot_lhs !== exl) $display("FAIL order_lhs[%0d]: got %h need %h", n, dot_lhs, exl); else n_pass++;
      n_checks++; if (dot_rhs !== exr) $display("FAIL order_rhs[%0d]: got %h need %h", n, dot_rhs, exr); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL order_busy[%0d]: got %0b need 1", n, busy); else n_pass++;
      step();
    end
    n_checks++; if (dot_lhs !== {2{32'hA0000001}}) $display("FAIL order_hold_lhs: got %h need %h", dot_lhs, {2{32'hA0000001}}); else n_pass++;
    n_checks++; if (dot_rhs !== {2{32'hB0000002}}) $display("FAIL order_hold_rhs: got %h need %h", dot_rhs, {2{32'hB0000002}}); else n_pass++;
    wait_done(cyc, rdy_low);
    n_checks++; if (out !== expo) $display("FAIL order_out: got %h need %h", out, expo); else n_pass++;
    handshake();
    dot_mode = 0;
  endtask

  task automatic test_backpressure();
    int cyc;
    bit rdy_low;
    int bad_out, bad_rdy, bad_ov;
    accept_job(A_M, B_M);
    wait_done(cyc, rdy_low);
    bad_out = 0; bad_rdy = 0; bad_ov = 0;
    lhs = TWO_M; rhs = B_M; in_valid = 1'b1;
    for (int t = 0; t < 10; t++) begin
      if (out !== P_AB) bad_out++;
      if (in_ready !== 1'b0) bad_rdy++;
      if (out_valid !== 1'b1) bad_ov++;
      step();
    end
    n_checks++; if (bad_out != 0) $display("FAIL bp_out_stable: got %0d bad cycles need 0", bad_out); else n_pass++;
    n_checks++; if (bad_rdy != 0) $display("FAIL bp_in_ready_low: got %0d bad cycles need 0", bad_rdy); else n_pass++;
    n_checks++; if (bad_ov != 0) $display("FAIL bp_out_valid_held: got %0d bad cycles need 0", bad_ov); else n_pass++;
    n_checks++; if (out !== P_AB) $display("FAIL bp_product: got %h need %h", out, P_AB); else n_pass++;
    handshake();
    n_checks++; if (busy !== 1'b0) $display("FAIL bp_not_accepted: busy got %0b need 0", busy); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_idle_ready: got %0b need 1", in_ready); else n_pass++;
    step();
    in_valid = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("FAIL bp_second_accepted: busy got %0b need 1", busy); else n_pass++;
    wait_done(cyc, rdy_low);
    n_checks++; if (out !== P_2B) $display("FAIL bp_second_out: got %h need %h", out, P_2B); else n_pass++;
    handshake();
  endtask

  task automatic test_reset_drain();
    int cyc;
    bit rdy_low;
    int bad;
    accept_job(A_M, B_M);
    for (int t = 0; t < I*K; t++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rd_out_valid: got %0b need 0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rd_busy: got %0b need 0", busy); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rd_in_ready: got %0b need 1", in_ready); else n_pass++;
    bad = 0;
    for (int t = 0; t < 6; t++) begin
      if (out !== '0 || out_valid !== 1'b0) bad++;
      step();
    end
    n_checks++; if (bad != 0) $display("FAIL rd_no_stale_write: got %0d bad cycles need 0", bad); else n_pass++;
    accept_job(ID_M, B_M);
    wait_done(cyc, rdy_low);
    n_checks++; if (cyc != LAT) $display("FAIL rd_latency: got %0d need %0d", cyc, LAT); else n_pass++;
    n_checks++; if (out !== B_M) $display("FAIL rd_next_out: got %h need %h", out, B_M); else n_pass++;
    handshake();
  endtask

  task automatic test_back_to_back();
    logic [I*J*FW-1:0] jl [3];
    logic [J*K*FW-1:0] jr [3];
    logic [I*K*FW-1:0] jp [3];
    logic [I*K*FW-1:0] expv;
    int sent, got, last_acc;
    bit acc_now;
    jl[0] = A_M;  jr[0] = B_M; jp[0] = P_AB;
    jl[1] = ID_M; jr[1] = R_M; jp[1] = R_M;
    jl[2] = TWO_M; jr[2] = B_M; jp[2] = P_2B;
    sent = 0; got = 0; last_acc = -1;
    lhs = jl[0]; rhs = jr[0];
    in_valid = 1'b1; out_ready = 1'b1;
    for (int t = 0; t < 200 && got < 3; t++) begin
      if (out_valid) begin
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        n_checks++; if (out !== expv) $display("FAIL b2b_out[%0d]: got %h need %h", got, out, expv); else n_pass++;
        got++;
      end
      acc_now = in_valid && in_ready;
      if (acc_now) begin
        if (last_acc >= 0) begin
          n_checks++; if (t - last_acc != PERIOD) $display("FAIL b2b_interval: got %0d need %0d", t - last_acc, PERIOD); else n_pass++;
        end
        last_acc = t;
        exp_q.push_back(jp[sent]);
        sent++;
      end
      step();
      if (acc_now) begin
        if (sent < 3) begin lhs = jl[sent]; rhs = jr[sent]; end
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++; if (got != 3) $display("FAIL b2b_count: got %0d need 3", got); else n_pass++;
  endtask

`ifdef MAT_MUL_SEQ_PERF_CNT_EN
  task automatic test_perf_cnt();
    int cyc;
    bit rdy_low;
    rst = 1'b1; step(); rst = 1'b0;
    accept_job(A_M, B_M); wait_done(cyc, rdy_low); handshake();
    accept_job(ID_M, B_M); wait_done(cyc, rdy_low);
    for (int t = 0; t < 5; t++) step();
    handshake();
    accept_job(TWO_M, B_M); wait_done(cyc, rdy_low); handshake();
    n_checks++; if (job_count !== 32'd3) $display("FAIL perf_job_count: got %0d need 3", job_count); else n_pass++;
    n_checks++; if (stall_count !== 32'd5) $display("FAIL perf_stall_count: got %0d need 5", stall_count); else n_pass++;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_ordering();
    test_backpressure();
    test_reset_drain();
    test_back_to_back();
`ifdef MAT_MUL_SEQ_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
